fifo_read_ctrl: RTL
===================

Name: fifo_read_ctrl

Overview:
Read-side control for the asynchronous FIFO; it is the counterpart of the write-side controller. It takes the Gray-coded write pointer from the write domain and synchronises it into the read clock domain with a 2-flop synchroniser. It keeps the binary read pointer, which addresses the FIFO memory read port, and the Gray read pointer, which is exported to the write domain. It generates a registered empty flag that blocks reads from an empty FIFO.

Parameters:
POINTER_WIDTH, 4, pointer width including the wrap bit; FIFO depth = 2^(POINTER_WIDTH-1)
ALMOST_EMPTY_THRESH, 2, occupancy at or below which ralmost_empty asserts (used only with the optional feature)

Ports:
rclk  input  1  read-domain clock, rising edge
rrst_n  input  1  reset, asynchronous, active-low
rinc  input  1  read request; honoured only when rempty=0
wptr  input  POINTER_WIDTH  Gray write pointer, asynchronous to rclk
raddr  output  POINTER_WIDTH-1  memory read address = rbin[POINTER_WIDTH-2:0]
rptr  output  POINTER_WIDTH  registered Gray read pointer, sent to the write-domain synchroniser
rempty  output  1  registered empty flag
ralmost_empty  output  1  registered almost-empty flag (see Optional Feature)

Behaviour:
- Reset (async assert, removal on the rclk domain):
  - rbin=0, rptr=0, rq1_wptr=0, rq2_wptr=0.
  - rempty=1, ralmost_empty=1.
  - Outputs clear immediately on assertion, including mid-transfer.
- Synchroniser:
  - rq1_wptr<=wptr; rq2_wptr<=rq1_wptr on every rclk edge.
  - No logic between the two flops.
  - wptr is never used except through rq1_wptr.
- Read pointer:
  - rbin_next = rbin + 1 when (rinc && !rempty); otherwise rbin_next = rbin.
  - Increment width is POINTER_WIDTH; it wraps naturally from all-ones to 0.
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - rbin<=rbin_next and rptr<=rgray_next on the same edge.
- raddr:
  - Combinational from rbin.
  - The memory presents data for raddr; a read completes on the edge where rinc && !rempty.
- Empty flag:
  - rempty <= (rgray_next == rq2_wptr), a full POINTER_WIDTH compare.
  - Assertion is immediate: the edge consuming the last word sets rempty=1.
  - Deassertion latency: wptr changes before edge N; rq1 updates at N, rq2 at N+1, rempty falls at N+2.
- rinc while rempty=1 is ignored: no pointer change, no error.
- Wrap: the MSB of rbin/rptr toggles every depth reads. Equal Gray codes mean empty; lap mismatch is never treated as empty.
- Gray rptr changes by exactly one bit per increment; this is a required property.

Optional Feature:
Macro FIFO_RD_ALMOST_EMPTY_EN.
- Defined:
  - rq2_wptr is converted Gray-to-binary (wbin_s).
  - occ = wbin_s - rbin_next, modulo 2^POINTER_WIDTH.
  - ralmost_empty <= (occ <= ALMOST_EMPTY_THRESH), registered.
  - Reset value 1.
  - Occupancy is pessimistic, lagging writes by the synchroniser latency.
- Undefined: ralmost_empty is tied to 1'b0; no conversion logic is built.

Test Plan:
- Reset: rrst_n=0 with wptr=4'b0101 -> rempty=1, rptr=4'b0000, raddr=3'b000, ralmost_empty=1; wptr has no effect until reset is released.
- Single word: after reset, wptr=4'b0001 held -> rempty falls at the 3rd rclk edge. Then rinc=1 for 1 cycle -> raddr 0->1, rptr=4'b0001, rempty=1 on that same edge.
- Underflow guard: rempty=1, rinc=1 for 5 cycles -> raddr, rptr and rempty unchanged.
- Wrap: write side advances to gray(16 mod 16) over time while reading continuously. After 8 reads, raddr=0 and rptr=4'b1100. After 16 reads, rptr=4'b0000. rempty asserts exactly when rptr==rq2_wptr, and every rptr transition is a 1-bit change.
- Mid-operation reset: rptr=4'b0110, rempty=0; pulse rrst_n low between edges -> outputs go to reset values without a clock; after release, the first read uses raddr=0.
- Almost-empty (macro defined, THRESH=2): wptr=gray(5)=4'b0111, rbin=0 -> ralmost_empty=0 after sync. After 3 reads, occ=2 -> ralmost_empty=1 on the 3rd read edge. Macro undefined -> ralmost_empty=0 throughout.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for an async FIFO: wptr sync, binary/Gray read pointer, empty flag.
// Latency: read pointer/empty update on the consuming edge; write visibility lags 2 rclk edges + 1 for rempty.
// Backpressure: rinc is ignored while rempty=1; no pointer movement, no error signalled.
//
// Ports:
//   rclk, rrst_n   read clock (rising edge), async active-low reset
//   rinc           read request, honoured only when the FIFO is not empty
//   wptr           Gray write pointer from the write clock domain
//   raddr          memory read address (low bits of the binary read pointer)
//   rptr           registered Gray read pointer for the write-domain synchroniser
//   rempty         registered empty flag
//   ralmost_empty  registered almost-empty flag; built only with FIFO_RD_ALMOST_EMPTY_EN,
//                  otherwise tied low
module fifo_read_ctrl #(
    parameter int POINTER_WIDTH       = 4,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic                     rinc,
    input  logic [POINTER_WIDTH-1:0] wptr,
    output logic [POINTER_WIDTH-2:0] raddr,
    output logic [POINTER_WIDTH-1:0] rptr,
    output logic                     rempty,
    output logic                     ralmost_empty
);

    localparam int PW = POINTER_WIDTH;

    logic [PW-1:0] rq1_wptr;
    logic [PW-1:0] rq2_wptr;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic          rd_en;

    // Plain two-flop synchroniser; nothing may sit between the stages.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rq1_wptr <= '0;
            rq2_wptr <= '0;
        end else begin
            rq1_wptr <= wptr;
            rq2_wptr <= rq1_wptr;
        end
    end

    assign rd_en      = rinc & ~rempty;
    assign rbin_next  = rbin + {{(PW-1){1'b0}}, rd_en};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);

    // Empty is computed from the next pointer so the edge that consumes the
    // last word raises rempty immediately. The full-width compare includes the
    // wrap bit, so a pointer one lap behind never looks empty.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbin_next;
            rptr   <= rgray_next;
            rempty <= (rgray_next == rq2_wptr);
        end
    end

    assign raddr = rbin[PW-2:0];

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

    logic [PW-1:0] wbin_s;
    logic [PW-1:0] occ;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i < PW; i++) begin
            wbin_s[i] = ^(rq2_wptr >> i);
        end
    end

    // Modular difference; the synchronised write pointer is stale, so this
    // under-reports occupancy and the flag errs on the safe side.
    assign occ = wbin_s - rbin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            ralmost_empty <= 1'b1;
        end else begin
            ralmost_empty <= (occ <= AE_THRESH);
        end
    end
`else
    assign ralmost_empty = 1'b0;
`endif

endmodule
